ysyx_25030081_rf_wb_ctrl: RTL

- Write-back controller and scoreboard for the 32-entry integer register file.
- Shares the RF's single write port between two write-back requesters: wb0 = EXU/ALU, wb1 = LSU load.
- Uses round-robin arbitration and a registered write stage.
- Tracks pending destination registers so the issue stage stalls on RAW/WAW hazards.
- Sits between the EXU/LSU and the RF write port; the IDU consumes iss_ready.

---
 rtl/ysyx_25030081_rf_pkg.sv | 18 +
 rtl/ysyx_25030081_rr_arb2.sv | 40 ++++
 rtl/ysyx_25030081_rf_wb_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/ysyx_25030081_rf_pkg.sv
// Shared constants and types for the register-file write-back controller.
package ysyx_25030081_rf_pkg;

   localparam int unsigned RF_ADDR_WIDTH = 5;
   localparam int unsigned DATA_WIDTH    = 32;
   localparam int unsigned NUM_REGS      = 2 ** RF_ADDR_WIDTH;

   typedef enum logic {
      WB_EXU = 1'b0,
      WB_LSU = 1'b1
   } wb_req_e;

   typedef struct packed {
      logic [RF_ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0]    data;
   } wb_req_t;

endpackage

// File: rtl/ysyx_25030081_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on a tie.
module ysyx_25030081_rr_arb2
   import ysyx_25030081_rf_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt_c
);

   wb_req_e ptr_q;
   wb_req_e ptr_n;

   // Grant is combinational and suppressed while reset is asserted.
   always_comb begin
      gnt_c = 2'b00;
      ptr_n = ptr_q;
      if (!rst) begin
         if (req == 2'b11) begin
            gnt_c = (ptr_q == WB_EXU) ? 2'b01 : 2'b10;
         end else begin
            gnt_c = req;
         end
      end
      if (gnt_c[0]) begin
         ptr_n = WB_LSU;
      end else if (gnt_c[1]) begin
         ptr_n = WB_EXU;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= WB_EXU;
      end else begin
         ptr_q <= ptr_n;
      end
   end

endmodule

// File: rtl/ysyx_25030081_rf_wb_ctrl.sv
// RF write-port arbiter, registered write stage and busy-bit scoreboard.
// Define YSYX_25030081_RF_WB_BYPASS_EN to let the committing register count as ready.
module ysyx_25030081_rf_wb_ctrl
   import ysyx_25030081_rf_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     iss_valid,
   input  logic [RF_ADDR_WIDTH-1:0] iss_rd,
   input  logic [RF_ADDR_WIDTH-1:0] iss_rs1,
   input  logic [RF_ADDR_WIDTH-1:0] iss_rs2,
   output logic                     iss_ready,
   input  logic                     wb0_valid,
   input  logic [RF_ADDR_WIDTH-1:0] wb0_addr,
   input  logic [DATA_WIDTH-1:0]    wb0_data,
   output logic                     wb0_ready,
   input  logic                     wb1_valid,
   input  logic [RF_ADDR_WIDTH-1:0] wb1_addr,
   input  logic [DATA_WIDTH-1:0]    wb1_data,
   output logic                     wb1_ready,
   output logic                     rf_wen,
   output logic [RF_ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0]    rf_wdata,
   output logic                     idle
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_n;
   logic [NUM_REGS-1:0] busy_chk;
   logic [1:0]          gnt_c;
   wb_req_t             win;
   logic                iss_fire;

   ysyx_25030081_rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   ({wb1_valid, wb0_valid}),
      .gnt_c (gnt_c)
   );

   assign wb0_ready = gnt_c[0];
   assign wb1_ready = gnt_c[1];

   assign win = gnt_c[1] ? wb_req_t'{addr: wb1_addr, data: wb1_data}
                         : wb_req_t'{addr: wb0_addr, data: wb0_data};

   // Busy view used by the hazard check.
   always_comb begin
      busy_chk = busy_q;
`ifdef YSYX_25030081_RF_WB_BYPASS_EN
      if (rf_wen) begin
         busy_chk[rf_waddr] = 1'b0;
      end
`endif
   end

   assign iss_ready = !(busy_chk[iss_rs1] | busy_chk[iss_rs2] | busy_chk[iss_rd]);
   assign iss_fire  = iss_valid & iss_ready;

   // Commit clears, issue sets (set wins on collision), flush clears everything.
   always_comb begin
      busy_n = busy_q;
      if (rf_wen) begin
         busy_n[rf_waddr] = 1'b0;
      end
      if (iss_fire && (iss_rd != '0)) begin
         busy_n[iss_rd] = 1'b1;
      end
      if (flush) begin
         busy_n = '0;
      end
      busy_n[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q   <= '0;
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         busy_q <= busy_n;
         rf_wen <= (|gnt_c) && (win.addr != '0);
         if (|gnt_c) begin
            rf_waddr <= win.addr;
            rf_wdata <= win.data;
         end
      end
   end

   assign idle = (busy_q == '0) & !rf_wen;

endmodule
